// File: rtl/param_register_file_pkg.sv
// ===========================================================================
// regfile_pkg: default datapath sizes, register address type, popcount helper. Rev 1.0
// ===========================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_NUM_RD = 2;

  // Widest pending vector the popcount helper covers (ADDR_W up to 5).
  localparam int POP_MAX_W = 32;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  function automatic int popcount(input logic [POP_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < POP_MAX_W; k++) begin
      n = n + int'(v[k]);
    end
    return n;
  endfunction

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/param_register_file_if.sv
// ===========================================================================
// param_register_file_if: decode/writeback bus of the register file. Rev 1.0
// ===========================================================================
`default_nettype none

interface param_register_file_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     stall;
  logic [ADDR_W:0]          pend_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input  rd_data, rd_pend, stall, pend_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output rd_data, rd_pend, stall, pend_count
  );

endinterface : param_register_file_if

`default_nettype wire

// File: rtl/param_register_file_scoreboard.sv
// ===========================================================================
// regfile_scoreboard: per-register pending bits and registered pending count. Rev 1.0
// ===========================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic                   i_issue_en,
  input  logic [ADDR_W-1:0]      i_issue_addr,
  output logic [(1<<ADDR_W)-1:0] o_pend,
  output logic [ADDR_W:0]        o_pend_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0]     r_pend;
  logic [CNT_W-1:0]     r_count;
  logic [DEPTH-1:0]     w_next;
  logic [POP_MAX_W-1:0] w_pop_vec;

  // Issue is applied after the clear so a same-edge new producer keeps the bit set.
  always_comb begin
    w_next = r_pend;
    if (i_wr_en) begin
      w_next[i_wr_addr] = 1'b0;
    end
    if (i_issue_en) begin
      w_next[i_issue_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      w_next[0] = 1'b0;
    end
  end

  always_comb begin
    w_pop_vec              = '0;
    w_pop_vec[DEPTH-1:0]   = w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= '0;
      r_count <= '0;
    end else begin
      r_pend  <= w_next;
      r_count <= CNT_W'(popcount(w_pop_vec));
    end
  end

  assign o_pend       = r_pend;
  assign o_pend_count = r_count;

endmodule : regfile_scoreboard

`default_nettype wire

// File: rtl/param_register_file.sv
// ===========================================================================
// param_register_file: DEPTH x DATA_W regfile, NUM_RD async reads, RAW scoreboard.
// Optional write-to-read forwarding under macro REGFILE_BYPASS_EN. Rev 1.0
// ===========================================================================
`default_nettype none

module param_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  param_register_file_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        r_regs [DEPTH];
  logic [DEPTH-1:0]         w_pend;
  logic [ADDR_W:0]          w_pend_count;
  logic                     w_wr_zero;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_pend;
  logic [ADDR_W-1:0]        w_addr;
  logic                     w_hit;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (bus.wr_en),
    .i_wr_addr    (bus.wr_addr),
    .i_issue_en   (bus.issue_en),
    .i_issue_addr (bus.issue_addr),
    .o_pend       (w_pend),
    .o_pend_count (w_pend_count)
  );

  assign w_wr_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= '0;
      end
    end else if (bus.wr_en && !w_wr_zero) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Forwarding is suppressed during reset so every read port shows zero.
  always_comb begin
    w_rd_data = '0;
    w_rd_pend = '0;
    w_addr    = '0;
    w_hit     = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      w_hit  = !reset && bus.wr_en && (bus.wr_addr == w_addr);
`else
      w_hit  = 1'b0;
`endif
      if (!((ZERO_REG != 0) && (w_addr == '0))) begin
        if (w_hit) begin
          w_rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
          w_rd_pend[i]                  = bus.issue_en && (bus.issue_addr == w_addr);
        end else begin
          w_rd_data[i*DATA_W +: DATA_W] = r_regs[w_addr];
          w_rd_pend[i]                  = w_pend[w_addr];
        end
      end
    end
  end

  assign bus.rd_data    = w_rd_data;
  assign bus.rd_pend    = w_rd_pend;
  assign bus.stall      = |w_rd_pend;
  assign bus.pend_count = w_pend_count;

endmodule : param_register_file

`default_nettype wire

// File: tb/tb_param_register_file.sv
// ===========================================================================
// tb_param_register_file: directed self-checking bench, default and ZERO_REG=1 instances. Rev 1.0
// ===========================================================================
`default_nettype none

module tb_param_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  param_register_file_if #(.DATA_W(10), .ADDR_W(3), .NUM_RD(2)) b0 ();
  param_register_file_if #(.DATA_W(10), .ADDR_W(3), .NUM_RD(2)) b1 ();

  param_register_file #(.DATA_W(10), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  param_register_file #(.DATA_W(10), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (b0.rd_data !== 20'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0h want 0", b0.rd_data); end
    n_chk++; if (b0.rd_pend !== 2'b00) begin n_fail++; $display("FAIL reset_rd_pend: got %0b want 0", b0.rd_pend); end
    n_chk++; if (b0.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", b0.stall); end
    n_chk++; if (b0.pend_count !== 4'd0) begin n_fail++; $display("FAIL reset_pend_count: got %0d want 0", b0.pend_count); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_write_read();
    logic [9:0] exp;
    for (int i = 0; i < 8; i++) begin
      exp        = 10'd1 << i;
      b0.wr_en   = 1'b1;
      b0.wr_addr = 3'(i);
      b0.wr_data = exp;
      @(negedge clk);
      b0.wr_en   = 1'b0;
      b0.rd_addr = {3'(i), 3'(i)};
      #1;
      n_chk++; if (b0.rd_data[9:0] !== exp) begin n_fail++; $display("FAIL wr_rd_p0 reg%0d: got %0d want %0d", i, b0.rd_data[9:0], exp); end
      n_chk++; if (b0.rd_data[19:10] !== exp) begin n_fail++; $display("FAIL wr_rd_p1 reg%0d: got %0d want %0d", i, b0.rd_data[19:10], exp); end
      n_chk++; if (b0.rd_pend !== 2'b00) begin n_fail++; $display("FAIL wr_rd_pend reg%0d: got %0b want 0", i, b0.rd_pend); end
    end
  endtask

  task automatic test_issue_clear();
    b0.issue_en   = 1'b1;
    b0.issue_addr = 3'd3;
    @(negedge clk);
    b0.issue_en   = 1'b0;
    b0.rd_addr    = {3'd0, 3'd3};
    #1;
    n_chk++; if (b0.rd_pend !== 2'b01) begin n_fail++; $display("FAIL issue_pend: got %0b want 01", b0.rd_pend); end
    n_chk++; if (b0.stall !== 1'b1) begin n_fail++; $display("FAIL issue_stall: got %0b want 1", b0.stall); end
    n_chk++; if (b0.pend_count !== 4'd1) begin n_fail++; $display("FAIL issue_count: got %0d want 1", b0.pend_count); end
    n_chk++; if (b0.rd_data[9:0] !== 10'd8) begin n_fail++; $display("FAIL issue_data: got %0d want 8", b0.rd_data[9:0]); end
    b0.wr_en   = 1'b1;
    b0.wr_addr = 3'd3;
    b0.wr_data = 10'h3FF;
    @(negedge clk);
    b0.wr_en   = 1'b0;
    #1;
    n_chk++; if (b0.rd_pend !== 2'b00) begin n_fail++; $display("FAIL clear_pend: got %0b want 00", b0.rd_pend); end
    n_chk++; if (b0.rd_data[9:0] !== 10'h3FF) begin n_fail++; $display("FAIL clear_data: got %0h want 3ff", b0.rd_data[9:0]); end
    n_chk++; if (b0.pend_count !== 4'd0) begin n_fail++; $display("FAIL clear_count: got %0d want 0", b0.pend_count); end
    n_chk++; if (b0.stall !== 1'b0) begin n_fail++; $display("FAIL clear_stall: got %0b want 0", b0.stall); end
  endtask

  task automatic test_issue_write();
    // Same register on one edge: data lands, new producer keeps it pending.
    b0.issue_en   = 1'b1;
    b0.issue_addr = 3'd5;
    b0.wr_en      = 1'b1;
    b0.wr_addr    = 3'd5;
    b0.wr_data    = 10'd77;
    @(negedge clk);
    b0.issue_en   = 1'b0;
    b0.wr_en      = 1'b0;
    b0.rd_addr    = {3'd0, 3'd5};
    #1;
    n_chk++; if (b0.rd_data[9:0] !== 10'd77) begin n_fail++; $display("FAIL same_data: got %0d want 77", b0.rd_data[9:0]); end
    n_chk++; if (b0.rd_pend !== 2'b01) begin n_fail++; $display("FAIL same_pend: got %0b want 01", b0.rd_pend); end
    n_chk++; if (b0.stall !== 1'b1) begin n_fail++; $display("FAIL same_stall: got %0b want 1", b0.stall); end
    n_chk++; if (b0.pend_count !== 4'd1) begin n_fail++; $display("FAIL same_count: got %0d want 1", b0.pend_count); end
    b0.issue_en   = 1'b1;
    b0.issue_addr = 3'd6;
    b0.wr_en      = 1'b1;
    b0.wr_addr    = 3'd4;
    b0.wr_data    = 10'd123;
    @(negedge clk);
    b0.issue_en   = 1'b0;
    b0.wr_en      = 1'b0;
    b0.rd_addr    = {3'd6, 3'd4};
    #1;
    n_chk++; if (b0.rd_data[9:0] !== 10'd123) begin n_fail++; $display("FAIL diff_data: got %0d want 123", b0.rd_data[9:0]); end
    n_chk++; if (b0.rd_data[19:10] !== 10'd64) begin n_fail++; $display("FAIL diff_data6: got %0d want 64", b0.rd_data[19:10]); end
    n_chk++; if (b0.rd_pend !== 2'b10) begin n_fail++; $display("FAIL diff_pend: got %0b want 10", b0.rd_pend); end
    n_chk++; if (b0.pend_count !== 4'd2) begin n_fail++; $display("FAIL diff_count: got %0d want 2", b0.pend_count); end
    b0.wr_en   = 1'b1;
    b0.wr_addr = 3'd5;
    b0.wr_data = 10'd77;
    @(negedge clk);
    b0.wr_addr = 3'd6;
    b0.wr_data = 10'd64;
    @(negedge clk);
    b0.wr_en   = 1'b0;
    #1;
    n_chk++; if (b0.pend_count !== 4'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", b0.pend_count); end
  endtask

  task automatic test_bypass();
    logic [9:0] exp;
    b0.rd_addr = {3'd2, 3'd1};
    b0.wr_en   = 1'b1;
    b0.wr_addr = 3'd2;
    b0.wr_data = 10'd500;
    #1;
    exp = BYP ? 10'd500 : 10'd4;
    n_chk++; if (b0.rd_data[19:10] !== exp) begin n_fail++; $display("FAIL byp_data: got %0d want %0d", b0.rd_data[19:10], exp); end
    n_chk++; if (b0.rd_data[9:0] !== 10'd2) begin n_fail++; $display("FAIL byp_other: got %0d want 2", b0.rd_data[9:0]); end
    n_chk++; if (b0.rd_pend !== 2'b00) begin n_fail++; $display("FAIL byp_pend: got %0b want 00", b0.rd_pend); end
    @(negedge clk);
    b0.wr_en = 1'b0;
    #1;
    n_chk++; if (b0.rd_data[19:10] !== 10'd500) begin n_fail++; $display("FAIL byp_after: got %0d want 500", b0.rd_data[19:10]); end
    b0.wr_en      = 1'b1;
    b0.wr_data    = 10'd501;
    b0.issue_en   = 1'b1;
    b0.issue_addr = 3'd2;
    #1;
    exp = BYP ? 10'd501 : 10'd500;
    n_chk++; if (b0.rd_data[19:10] !== exp) begin n_fail++; $display("FAIL byp_iss_data: got %0d want %0d", b0.rd_data[19:10], exp); end
    n_chk++; if (b0.rd_pend[1] !== BYP) begin n_fail++; $display("FAIL byp_iss_pend: got %0b want %0b", b0.rd_pend[1], BYP); end
    @(negedge clk);
    b0.wr_en    = 1'b0;
    b0.issue_en = 1'b0;
    #1;
    n_chk++; if (b0.rd_pend !== 2'b10) begin n_fail++; $display("FAIL byp_iss_after: got %0b want 10", b0.rd_pend); end
    n_chk++; if (b0.rd_data[19:10] !== 10'd501) begin n_fail++; $display("FAIL byp_iss_val: got %0d want 501", b0.rd_data[19:10]); end
    b0.wr_en = 1'b1;
    @(negedge clk);
    b0.wr_en = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      b0.issue_en   = 1'b1;
      b0.issue_addr = 3'(i);
      @(negedge clk);
    end
    b0.issue_en = 1'b0;
    b0.rd_addr  = {3'd7, 3'd3};
    #1;
    n_chk++; if (b0.pend_count !== 4'd8) begin n_fail++; $display("FAIL all_count: got %0d want 8", b0.pend_count); end
    n_chk++; if (b0.stall !== 1'b1) begin n_fail++; $display("FAIL all_stall: got %0b want 1", b0.stall); end
    #2;
    reset      = 1'b1;
    b0.wr_en   = 1'b1;
    b0.wr_addr = 3'd1;
    b0.wr_data = 10'd55;
    #1;
    n_chk++; if (b0.pend_count !== 4'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", b0.pend_count); end
    n_chk++; if (b0.stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall: got %0b want 0", b0.stall); end
    n_chk++; if (b0.rd_data !== 20'd0) begin n_fail++; $display("FAIL mid_data: got %0h want 0", b0.rd_data); end
    n_chk++; if (b0.rd_pend !== 2'b00) begin n_fail++; $display("FAIL mid_pend: got %0b want 00", b0.rd_pend); end
    @(negedge clk);
    reset      = 1'b0;
    b0.wr_en   = 1'b0;
    b0.rd_addr = {3'd1, 3'd3};
    #1;
    n_chk++; if (b0.rd_data !== 20'd0) begin n_fail++; $display("FAIL post_rst_data: got %0h want 0", b0.rd_data); end
  endtask

  task automatic test_zero_reg();
    b1.rd_addr    = {3'd1, 3'd0};
    b1.wr_en      = 1'b1;
    b1.wr_addr    = 3'd0;
    b1.wr_data    = 10'd9;
    b1.issue_en   = 1'b1;
    b1.issue_addr = 3'd0;
    #1;
    n_chk++; if (b1.rd_data[9:0] !== 10'd0) begin n_fail++; $display("FAIL z_byp_data: got %0d want 0", b1.rd_data[9:0]); end
    n_chk++; if (b1.rd_pend[0] !== 1'b0) begin n_fail++; $display("FAIL z_byp_pend: got %0b want 0", b1.rd_pend[0]); end
    @(negedge clk);
    b1.issue_en = 1'b0;
    b1.wr_addr  = 3'd1;
    #1;
    n_chk++; if (b1.rd_data[9:0] !== 10'd0) begin n_fail++; $display("FAIL z_data: got %0d want 0", b1.rd_data[9:0]); end
    n_chk++; if (b1.pend_count !== 4'd0) begin n_fail++; $display("FAIL z_count: got %0d want 0", b1.pend_count); end
    n_chk++; if (b1.stall !== 1'b0) begin n_fail++; $display("FAIL z_stall: got %0b want 0", b1.stall); end
    @(negedge clk);
    b1.wr_en = 1'b0;
    #1;
    n_chk++; if (b1.rd_data[19:10] !== 10'd9) begin n_fail++; $display("FAIL z_reg1: got %0d want 9", b1.rd_data[19:10]); end
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    reset         = 1'b1;
    b0.rd_addr    = '0;
    b0.wr_en      = 1'b0;
    b0.wr_addr    = '0;
    b0.wr_data    = '0;
    b0.issue_en   = 1'b0;
    b0.issue_addr = '0;
    b1.rd_addr    = '0;
    b1.wr_en      = 1'b0;
    b1.wr_addr    = '0;
    b1.wr_data    = '0;
    b1.issue_en   = 1'b0;
    b1.issue_addr = '0;
    test_reset();
    test_write_read();
    test_issue_clear();
    test_issue_write();
    test_bypass();
    test_reset_mid();
    test_zero_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_param_register_file

`default_nettype wire
